// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one external memory port between
// the instruction-fetch side and the data side, with a per-transaction timeout.
//
// Ports:
//   clk, sync_rst_n        clock, synchronous active-low reset
//   clk_en                 global enable; low freezes all state and outputs
//   inst_req/addr          instruction read request (10-bit word address)
//   inst_rdata/done        fetched word and one-cycle completion pulse
//   data_req/we/addr/wdata data request (8-bit address, 8-bit write data)
//   data_rdata/done        read byte and one-cycle completion pulse
//   err                    timeout flag, pulses together with a done pulse
//   ext_req/we/addr/wdata  registered external request; ext_addr[10]=1 is data space
//   ext_rdata/ack          external read data and completion
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  input  logic        inst_req,
  input  logic [9:0]  inst_addr,
  output logic [15:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [7:0]  data_addr,
  input  logic [7:0]  data_wdata,
  output logic [7:0]  data_rdata,
  output logic        data_done,
  output logic        err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [10:0] ext_addr,
  output logic [15:0] ext_wdata,
  input  logic [15:0] ext_rdata,
  input  logic        ext_ack
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant_data;  // 0 = inst granted last, 1 = data
  logic             grant_data;       // side owning the current transaction

  // Data wins when alone, or on a tie when inst was served last.
  logic pick_data_c;
  assign pick_data_c = data_req && (!inst_req || !last_grant_data);

  // Transaction ends on ack, or when the wait budget is exhausted.
  logic finish_c;
  assign finish_c = ext_ack || (cnt == TIMEOUT_CNT);

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      last_grant_data <= 1'b0;
      grant_data      <= 1'b0;
      ext_req         <= 1'b0;
      ext_we          <= 1'b0;
      ext_addr        <= '0;
      ext_wdata       <= '0;
      inst_done       <= 1'b0;
      data_done       <= 1'b0;
      err             <= 1'b0;
      inst_rdata      <= '0;
      data_rdata      <= '0;
    end else if (clk_en) begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            grant_data <= pick_data_c;
            cnt        <= '0;
            ext_req    <= 1'b1;
            if (pick_data_c) begin
              ext_addr  <= {1'b1, 2'b00, data_addr};
              ext_wdata <= {8'h00, data_wdata};
              ext_we    <= data_we;
            end else begin
              ext_addr  <= {1'b0, inst_addr};
              ext_wdata <= '0;
              ext_we    <= 1'b0;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish_c) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            // Ack takes priority over a timeout landing in the same cycle.
            err     <= !ext_ack;
            if (grant_data) begin
              data_done  <= 1'b1;
              data_rdata <= ext_ack ? ext_rdata[7:0] : 8'h00;
            end else begin
              inst_done  <= 1'b1;
              inst_rdata <= ext_ack ? ext_rdata : 16'h0000;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Requests are not sampled here, so a requester may drop req on done.
          last_grant_data <= grant_data;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A second instance with TIMEOUT=3 shares the inputs and is used for the
// timeout scenario only.
module tb_mem_arbiter;

  logic        clk;
  logic        sync_rst_n;
  logic        clk_en;
  logic        inst_req;
  logic [9:0]  inst_addr;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [7:0]  data_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;

  logic [15:0] inst_rdata, inst_rdata_t;
  logic        inst_done, inst_done_t;
  logic [7:0]  data_rdata, data_rdata_t;
  logic        data_done, data_done_t;
  logic        err, err_t;
  logic        ext_req, ext_req_t;
  logic        ext_we, ext_we_t;
  logic [10:0] ext_addr, ext_addr_t;
  logic [15:0] ext_wdata, ext_wdata_t;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .err(err), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  mem_arbiter #(.TIMEOUT(3)) dut_to (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata_t), .inst_done(inst_done_t),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata_t), .data_done(data_done_t),
    .err(err_t), .ext_req(ext_req_t), .ext_we(ext_we_t), .ext_addr(ext_addr_t),
    .ext_wdata(ext_wdata_t), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; observe and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sync_rst_n = 1'b0; clk_en = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    ext_rdata = '0; ext_ack = 1'b0;
    step(); step();

    // Reset values
    chk("rst_ext_req",   32'(ext_req),    32'h0);
    chk("rst_ext_we",    32'(ext_we),     32'h0);
    chk("rst_ext_addr",  32'(ext_addr),   32'h0);
    chk("rst_ext_wdata", 32'(ext_wdata),  32'h0);
    chk("rst_done",      32'({inst_done, data_done, err}), 32'h0);
    chk("rst_rdata",     32'({inst_rdata, data_rdata}),    32'h0);
    sync_rst_n = 1'b1;

    // Single data write, ack in first BUSY cycle
    data_req = 1'b1; data_we = 1'b1; data_addr = 8'h3C; data_wdata = 8'hA5;
    step();
    chk("wr_ext_req",   32'(ext_req),   32'h1);
    chk("wr_ext_addr",  32'(ext_addr),  32'h43C);
    chk("wr_ext_wdata", 32'(ext_wdata), 32'h00A5);
    chk("wr_ext_we",    32'(ext_we),    32'h1);
    chk("wr_no_done",   32'(data_done), 32'h0);
    ext_ack = 1'b1; ext_rdata = 16'h1234;
    step();
    chk("wr_data_done", 32'(data_done),  32'h1);
    chk("wr_err",       32'(err),        32'h0);
    chk("wr_ext_req_lo",32'(ext_req),    32'h0);
    chk("wr_ext_we_lo", 32'(ext_we),     32'h0);
    chk("wr_rdata",     32'(data_rdata), 32'h34);
    data_req = 1'b0; data_we = 1'b0; ext_ack = 1'b0;
    step();
    chk("wr_done_pulse", 32'(data_done), 32'h0);
    chk("wr_idle_req",   32'(ext_req),   32'h0);

    // Instruction fetch, ack in 5th BUSY cycle
    inst_req = 1'b1; inst_addr = 10'h2F1; ext_rdata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("if_ext_req_hi", 32'(ext_req), 32'h1);
      chk("if_no_done",    32'(inst_done), 32'h0);
      if (i == 4) ext_ack = 1'b1;
    end
    chk("if_ext_addr", 32'(ext_addr), 32'h2F1);
    chk("if_ext_we",   32'(ext_we),   32'h0);
    step();
    chk("if_ext_req_lo", 32'(ext_req),    32'h0);
    chk("if_inst_done",  32'(inst_done),  32'h1);
    chk("if_rdata",      32'(inst_rdata), 32'hBEEF);
    chk("if_data_done",  32'(data_done),  32'h0);
    inst_req = 1'b0; ext_ack = 1'b0;
    step();

    // Ties after reset: data, inst, data (data re-requests while inst waits)
    sync_rst_n = 1'b0; step(); sync_rst_n = 1'b1;
    inst_req = 1'b1; inst_addr = 10'h100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h55;
    ext_ack = 1'b1; ext_rdata = 16'h00C3;
    step();
    chk("tie1_addr",  32'(ext_addr), 32'h455);
    chk("tie1_req",   32'(ext_req),  32'h1);
    step();
    chk("tie1_done",  32'({inst_done, data_done}), 32'h1);
    chk("tie1_gap_done", 32'(ext_req), 32'h0);
    step();
    chk("tie1_gap_idle", 32'(ext_req), 32'h0);
    step();
    chk("tie2_req",   32'(ext_req),  32'h1);
    chk("tie2_addr",  32'(ext_addr), 32'h100);
    step();
    chk("tie2_done",  32'({inst_done, data_done}), 32'h2);
    chk("tie2_rdata", 32'(inst_rdata), 32'h00C3);
    inst_req = 1'b0;
    step(); step();
    chk("tie3_addr",  32'(ext_addr), 32'h455);
    step();
    chk("tie3_done",  32'({inst_done, data_done}), 32'h1);
    data_req = 1'b0; ext_ack = 1'b0;
    step();

    // Timeout on the TIMEOUT=3 instance
    sync_rst_n = 1'b0; step(); sync_rst_n = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h10; ext_rdata = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_ext_req_hi", 32'(ext_req_t), 32'h1);
      chk("to_no_done",    32'({data_done_t, err_t}), 32'h0);
    end
    step();
    chk("to_ext_req_lo", 32'(ext_req_t),    32'h0);
    chk("to_data_done",  32'(data_done_t),  32'h1);
    chk("to_err",        32'(err_t),        32'h1);
    chk("to_rdata",      32'(data_rdata_t), 32'h0);
    data_req = 1'b0;
    step();
    chk("to_err_pulse",  32'(err_t), 32'h0);

    // clk_en stall mid-BUSY with ack held
    sync_rst_n = 1'b0; step(); sync_rst_n = 1'b1;
    inst_req = 1'b1; inst_addr = 10'h0AA; ext_rdata = 16'h1357;
    step();
    chk("ce_req", 32'(ext_req), 32'h1);
    clk_en = 1'b0; ext_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ce_frozen_req",  32'(ext_req),   32'h1);
      chk("ce_frozen_addr", 32'(ext_addr),  32'h0AA);
      chk("ce_no_done",     32'(inst_done), 32'h0);
    end
    clk_en = 1'b1;
    step();
    chk("ce_done",  32'(inst_done),  32'h1);
    chk("ce_rdata", 32'(inst_rdata), 32'h1357);
    inst_req = 1'b0; ext_ack = 1'b0;
    step();

    // Reset mid-BUSY, request still held
    data_req = 1'b1; data_we = 1'b1; data_addr = 8'h77; data_wdata = 8'h11;
    step();
    chk("rb_req", 32'(ext_req), 32'h1);
    sync_rst_n = 1'b0;
    step();
    chk("rb_ext_req",  32'(ext_req),   32'h0);
    chk("rb_ext_addr", 32'(ext_addr),  32'h0);
    chk("rb_ext_we",   32'(ext_we),    32'h0);
    chk("rb_ext_wd",   32'(ext_wdata), 32'h0);
    chk("rb_no_done",  32'({inst_done, data_done, err}), 32'h0);
    sync_rst_n = 1'b1;
    step();
    chk("rb_reissue_req",  32'(ext_req),   32'h1);
    chk("rb_reissue_addr", 32'(ext_addr),  32'h477);
    chk("rb_reissue_wd",   32'(ext_wdata), 32'h0011);
    chk("rb_no_done2",     32'(data_done), 32'h0);
    ext_ack = 1'b1;
    step();
    chk("rb_done", 32'(data_done), 32'h1);
    data_req = 1'b0; ext_ack = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
